regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the core register file.
- Configurable data width, depth, read-port count and write-port count.
- Adds same-cycle write-to-read bypass with deterministic write-port priority.
- Adds a pending-write scoreboard for long-latency producers (loads, divider) and a post-reset hardware clear sequence, so the contents are defined before first use.
- Sits in the decode stage: read ports feed operand muxes, and write ports are driven by the WB and long-latency retire paths.

Parameters:
- DATA_W, 32, register data width in bits.
- ADDR_W, 5, register address width; depth REG_NUM = 2**ADDR_W.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 2, number of write ports; a higher index has higher priority.
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes and pend_set.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- wen  in  NUM_WR  per-port write enable.
- waddr  in  NUM_WR*ADDR_W  write addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- wdata  in  NUM_WR*DATA_W  write data, packed the same way.
- raddr  in  NUM_RD*ADDR_W  read addresses, packed.
- rdata  out  NUM_RD*DATA_W  read data, combinational, packed.
- rpend  out  NUM_RD  read-port register has an outstanding pending write.
- pend_set  in  1  mark register pend_addr as pending.
- pend_addr  in  ADDR_W  scoreboard set address.
- init_done  out  1  clear sequence finished; the file is usable.

Behaviour:
States:
- CLEAR and RUN, held in a state register.
- Whenever rst==0 at a rising clk: state<=CLEAR, clr_ptr<=0, all pending bits<=0, init_done<=0.
- This applies at any time, including mid-CLEAR or mid-RUN; storage is not reset directly.

CLEAR:
- Each cycle: register[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
- Entry 0 is also written, even when ZERO_REG=1.
- In the cycle that clr_ptr==REG_NUM-1: state<=RUN and init_done<=1.
- init_done therefore rises exactly REG_NUM cycles after the first cycle with rst==1.
- wen and pend_set are ignored.
- rdata reads 0 and rpend reads 0 on all ports.

RUN, write:
- At the rising edge, for each address, the highest-index port k with wen[k] and a matching waddr writes wdata[k].
- Lower-index ports to the same address are dropped.
- With ZERO_REG=1, writes to address 0 are dropped.

RUN, read (combinational, in priority order):
- (a) ZERO_REG and raddr==0 -> 0.
- (b) Highest-index port k with wen[k] and waddr[k]==raddr -> wdata[k] (bypass).
- (c) register[raddr].

Scoreboard:
- One bit per entry.
- pend_set in RUN sets pend[pend_addr] at the edge.
- Any enabled write in RUN clears pend[waddr].
- Set and write to the same address in one cycle: set wins, so the bit ends at 1.
- pend_set to address 0 is ignored when ZERO_REG=1.
- rpend[i] = pend_q[raddr[i]] AND NOT (write to raddr[i] this cycle).
- A same-cycle pend_set does not affect rpend until the next cycle.
- rpend is forced to 0 for address 0 when ZERO_REG=1.

Latency and outputs:
- Write-to-storage is 1 cycle; write-to-read is 0 cycles via bypass.
- There are no registered data outputs.
- Reset values: init_done=0; rdata=0 and rpend=0 while in CLEAR.

Decomposition:
- Shared package/header (veririscv_core.vh): default DATA_W and ADDR_W (matching DATA_RANGE and RF_RANGE), and the state encodings RF_CLEAR and RF_RUN.
- The REG_NUM derivation is local.
- One sub-module, regfile_scoreboard. It holds the pend bits and implements set, clear and the set-wins rule. It has NUM_WR write-clear ports, the pend_set port and NUM_RD lookup ports, and it receives the state enable from the parent.
- The storage array, bypass muxes and clear FSM stay in regfile_mp.

Test Plan:
1. Clear sequence. Stimulus: default params, rst low 3 cycles, then high; wen[0]=1 to reg 5 with 0xDEAD during CLEAR. Response: init_done rises after exactly 32 cycles; afterwards all 32 reads return 0, including reg 5.
2. Bypass and priority. Stimulus: in RUN, one cycle with wen=2'b11, both waddr=7, wdata0=0x1111, wdata1=0x2222, raddr0=7. Response: rdata0=0x2222 in the same cycle; the next cycle, reading reg 7 from storage also gives 0x2222.
3. Zero register. Stimulus: write 0xFFFFFFFF to reg 0 on both ports, then pend_set to reg 0. Response: rdata for raddr 0 is 0 in all cycles and rpend=0. With ZERO_REG=0, the same write reads 0xFFFFFFFF on the next cycle.
4. Scoreboard. Stimulus: pend_set to reg 9. Response: rpend=1 for raddr 9 from the next cycle. Then write reg 9 with 0xABCD: rpend=0 in the write cycle (bypass) and stays 0 afterwards.
5. Set-wins collision. Stimulus: reg 3 is pending, then a single cycle with pend_set to reg 3 plus wen[1] to reg 3 with 0x55. Response: rpend for reg 3 is 1 on the next cycle, and data reads 0x55.
6. Reset mid-operation. Stimulus: RUN with pend bits 2 and 4 set and reg 2 = 0x77; pulse rst low for 1 cycle. Response: init_done drops to 0, rpend is all 0, and after 32 cycles reg 2 reads 0.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared defaults and state encoding for the multi-port register file.
package regfile_mp_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by long-latency issue,
// cleared by retiring writes; a same-cycle set beats a clear.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run_en,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD-1:0]        rpend
);

  localparam int REG_NUM = 2 ** ADDR_W;

  logic [REG_NUM-1:0] pend_q;
  logic [REG_NUM-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wen[k]) pend_d[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (pend_set && !(ZERO_REG != 0 && pend_addr == '0)) pend_d[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_q <= '0;
    end else if (run_en) begin
      pend_q <= pend_d;
    end
  end

  // A write retiring this cycle resolves the hazard, so it masks the lookup.
  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    rpend = '0;
    a     = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a   = raddr[i*ADDR_W +: ADDR_W];
      hit = 1'b0;
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wen[k] && waddr[k*ADDR_W +: ADDR_W] == a) hit = 1'b1;
      end
      rpend[i] = run_en && pend_q[a] && !hit && !(ZERO_REG != 0 && a == '0);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, pending-write
// scoreboard and a post-reset hardware clear of every entry.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rpend,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr,
  output logic                     init_done
);

  localparam int REG_NUM = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(REG_NUM - 1);

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              clearing, running;
  logic [DATA_W-1:0] mem [REG_NUM];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RF_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == RF_CLEAR) begin
      clr_ptr_d = clr_ptr_q + ADDR_W'(1);
      if (clr_ptr_q == LAST_PTR) state_d = RF_RUN;
    end
  end

  // init_done is exactly "state is RUN", so it shares the state register.
  always_comb begin
    clearing  = (state_q == RF_CLEAR);
    running   = (state_q == RF_RUN);
    init_done = running;
  end

  // Ascending port loop: the last NBA to an entry wins, giving high-index priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (clearing) begin
        mem[clr_ptr_q] <= '0;
      end else begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (wen[k] && !(ZERO_REG != 0 && waddr[k*ADDR_W +: ADDR_W] == '0))
            mem[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] v;
    rdata = '0;
    a     = '0;
    v     = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a = raddr[i*ADDR_W +: ADDR_W];
      v = mem[a];
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wen[k] && waddr[k*ADDR_W +: ADDR_W] == a) v = wdata[k*DATA_W +: DATA_W];
      end
      if (!running || (ZERO_REG != 0 && a == '0)) v = '0;
      rdata[i*DATA_W +: DATA_W] = v;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run_en   (running),
    .wen      (wen),
    .waddr    (waddr),
    .pend_set (pend_set),
    .pend_addr(pend_addr),
    .raddr    (raddr),
    .rpend    (rpend)
  );

endmodule
